resolve_noite: RTL and testbench
================================

// Module: resolve_noite
// PURPOSE
//  Night-phase resolver; sits directly downstream of the seed register (jogo_atual).
//  Takes the 10-bit role vector and the alive mask. Collects the wolf's target, then the doctor's protected player.
//  Resolves the death and updates the alive mask. Reports victim and win conditions to the game controller.
// PARAMETERS
//  N_JOG   5   number of players; role vector is 2*N_JOG bits
//  W_IDX   3   width of a player index
// PORTS
//  clock         in   1        system clock, rising edge
//  reset         in   1        synchronous, active-low; all state/outputs to reset values
//  novo_jogo     in   1        pulse in OCIOSO: vivos <= all ones; ignored elsewhere
//  inicia        in   1        pulse in OCIOSO: start a night; ignored elsewhere
//  jogo          in   10       roles; player i at bits [9-2i:8-2i]; 00 aldeao, 01 lobo, 10 medico, 11 invalid
//  jogador_sel   in   3        player index currently selected by the UI
//  confirma      in   1        one-cycle pulse (edge-detected button) committing jogador_sel
//  vivos         out  5        alive mask, bit i = player i alive
//  morto_idx     out  3        index of player killed last night; valid when houve_morte=1
//  houve_morte   out  1        1 = last night killed someone; 0 = saved or no night yet
//  erro_sel      out  1        one-cycle pulse: confirma with illegal jogador_sel
//  pronto        out  1        one-cycle pulse: night resolved, outputs updated
//  vitoria_lobo  out  1        level: wolf alive and alive count <= 2
//  vitoria_aldeoes out 1       level: wolf dead
//  db_estado     out  5        current FSM state code
// BEHAVIOUR
//  Reset: state OCIOSO, vivos=5'b11111, morto_idx=0, houve_morte=0, all pulses 0, registered targets 0.
//  Wolf index = position of the single 01 field; doctor index = position of the 10 field.
//  Roles are decoded combinationally from jogo. jogo must hold steady from inicia until pronto.
//  States (db_estado): OCIOSO=0, ESCOLHE_LOBO=1, ESCOLHE_MEDICO=2, RESOLVE=3, FIM=4; any other -> OCIOSO, db_estado=5'b11111.
//  OCIOSO: inicia=1 -> ESCOLHE_LOBO. novo_jogo and inicia in the same cycle: both act (fresh mask, night starts).
//  Entering ESCOLHE_LOBO: if wolf dead, go directly to FIM with houve_morte=0 (no night).
//  ESCOLHE_LOBO on confirma: legal if sel<5, vivos[sel]=1 and sel != wolf.
//   Legal -> alvo_lobo<=sel, next ESCOLHE_MEDICO (or RESOLVE if doctor dead).
//   Illegal -> erro_sel=1 next cycle, state unchanged.
//  ESCOLHE_MEDICO on confirma: legal if sel<5 and vivos[sel]=1; self-protection allowed.
//   Legal -> alvo_med<=sel, next RESOLVE. Illegal -> erro_sel pulse, stay.
//  RESOLVE (1 cycle): if doctor dead or alvo_med != alvo_lobo: vivos[alvo_lobo]<=0, morto_idx<=alvo_lobo, houve_morte<=1.
//   Otherwise houve_morte<=0 and morto_idx is unchanged. Next FIM.
//  FIM (1 cycle): pronto=1; next OCIOSO.
//  Latency: final legal confirma at edge k -> RESOLVE at k+1 -> pronto high during cycle after k+2.
//  confirma outside ESCOLHE_* is ignored. jogador_sel is sampled only with confirma.
//  Victory flags: combinational from vivos and the decoded wolf. alive count = popcount(vivos), 3-bit.
//  morto_idx/houve_morte hold until the next RESOLVE or reset.
//  Reset asserted mid-night: next edge -> OCIOSO, mask restored, no pronto.
//  jogo with zero or multiple 01 fields is invalid. Behaviour is then undefined except that the FSM never leaves the legal state set.
// TESTING
//  1 Reset low 1 cycle -> vivos=11111, db_estado=0, pronto=0, houve_morte=0.
//  2 jogo=01_10_00_00_00; inicia; sel=3+confirma; sel=1+confirma -> pronto 2 cycles later, vivos=10111, morto_idx=3, houve_morte=1.
//  3 Same jogo; wolf sel=2, doctor sel=2 -> vivos unchanged, houve_morte=0, pronto pulses once.
//  4 Wolf stage: sel=0 (self), then sel=6, then dead player -> erro_sel each time, db_estado stays 1; then sel=4 -> advances to 2.
//  5 Kill players until vivos has wolf + 1 alive -> vitoria_lobo=1. Separately, vivos wolf bit cleared -> vitoria_aldeoes=1; inicia goes straight to FIM.
//  6 reset low while in ESCOLHE_MEDICO -> next cycle OCIOSO, vivos=11111, no pronto. Check novo_jogo ignored outside OCIOSO.

Source files
------------

// File: rtl/resolve_noite.sv
// Night-phase resolver: collects the wolf's target and the doctor's protection,
// applies the kill to the alive mask and reports the victim and victory flags.
module resolve_noite #(
    parameter int N_JOG = 5,
    parameter int W_IDX = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               novo_jogo,
    input  logic               inicia,
    input  logic [2*N_JOG-1:0] jogo,
    input  logic [W_IDX-1:0]   jogador_sel,
    input  logic               confirma,
    output logic [N_JOG-1:0]   vivos,
    output logic [W_IDX-1:0]   morto_idx,
    output logic               houve_morte,
    output logic               erro_sel,
    output logic               pronto,
    output logic               vitoria_lobo,
    output logic               vitoria_aldeoes,
    output logic [4:0]         db_estado
);

    localparam int NSEL = 1 << W_IDX;

    typedef enum logic [2:0] {
        OCIOSO         = 3'd0,
        ESCOLHE_LOBO   = 3'd1,
        ESCOLHE_MEDICO = 3'd2,
        RESOLVE        = 3'd3,
        FIM            = 3'd4
    } estado_t;

    estado_t            estado_q, estado_d;
    logic [N_JOG-1:0]   vivos_q, vivos_d;
    logic [W_IDX-1:0]   alvo_lobo_q, alvo_lobo_d;
    logic [W_IDX-1:0]   alvo_med_q, alvo_med_d;
    logic [W_IDX-1:0]   morto_q, morto_d;
    logic               houve_q, houve_d;
    logic               erro_q, erro_d;
    logic               pronto_q, pronto_d;

    logic [W_IDX-1:0]   lobo_idx, med_idx;
    logic               lobo_ok, med_ok;
    logic [NSEL-1:0]    vivos_ext;
    logic               lobo_vivo, lobo_vivo_novo, med_vivo, sel_vivo;
    logic [2:0]         vivos_cnt;

    // Role decode; the wider alive vector makes out-of-range selections read as dead.
    always_comb begin
        lobo_idx = '0;
        lobo_ok  = 1'b0;
        med_idx  = '0;
        med_ok   = 1'b0;
        for (int i = 0; i < N_JOG; i++) begin
            if (jogo[2*N_JOG-1-2*i -: 2] == 2'b01) begin
                lobo_idx = W_IDX'(i);
                lobo_ok  = 1'b1;
            end
            if (jogo[2*N_JOG-1-2*i -: 2] == 2'b10) begin
                med_idx = W_IDX'(i);
                med_ok  = 1'b1;
            end
        end
    end

    assign vivos_ext      = NSEL'(vivos_q);
    assign lobo_vivo      = lobo_ok & vivos_ext[lobo_idx];
    assign lobo_vivo_novo = lobo_ok & (novo_jogo | vivos_ext[lobo_idx]);
    assign med_vivo       = med_ok & vivos_ext[med_idx];
    assign sel_vivo       = vivos_ext[jogador_sel];

    always_comb begin
        vivos_cnt = '0;
        for (int i = 0; i < N_JOG; i++) begin
            vivos_cnt = vivos_cnt + {2'b00, vivos_q[i]};
        end
    end

    always_comb begin
        estado_d    = estado_q;
        vivos_d     = vivos_q;
        alvo_lobo_d = alvo_lobo_q;
        alvo_med_d  = alvo_med_q;
        morto_d     = morto_q;
        houve_d     = houve_q;
        erro_d      = 1'b0;
        pronto_d    = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (novo_jogo) begin
                    vivos_d = '1;
                end
                if (inicia) begin
                    if (lobo_vivo_novo) begin
                        estado_d = ESCOLHE_LOBO;
                    end else begin
                        estado_d = FIM;
                        houve_d  = 1'b0;
                    end
                end
            end
            ESCOLHE_LOBO: begin
                if (confirma) begin
                    if (sel_vivo && jogador_sel != lobo_idx) begin
                        alvo_lobo_d = jogador_sel;
                        estado_d    = med_vivo ? ESCOLHE_MEDICO : RESOLVE;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            ESCOLHE_MEDICO: begin
                if (confirma) begin
                    if (sel_vivo) begin
                        alvo_med_d = jogador_sel;
                        estado_d   = RESOLVE;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            RESOLVE: begin
                // A dead doctor leaves a stale alvo_med_q, so it never saves anyone.
                if (!med_vivo || alvo_med_q != alvo_lobo_q) begin
                    vivos_d = vivos_q & ~(N_JOG'(1) << alvo_lobo_q);
                    morto_d = alvo_lobo_q;
                    houve_d = 1'b1;
                end else begin
                    houve_d = 1'b0;
                end
                estado_d = FIM;
            end
            FIM: begin
                pronto_d = 1'b1;
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q    <= OCIOSO;
            vivos_q     <= '1;
            alvo_lobo_q <= '0;
            alvo_med_q  <= '0;
            morto_q     <= '0;
            houve_q     <= 1'b0;
            erro_q      <= 1'b0;
            pronto_q    <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            vivos_q     <= vivos_d;
            alvo_lobo_q <= alvo_lobo_d;
            alvo_med_q  <= alvo_med_d;
            morto_q     <= morto_d;
            houve_q     <= houve_d;
            erro_q      <= erro_d;
            pronto_q    <= pronto_d;
        end
    end

    assign vivos           = vivos_q;
    assign morto_idx       = morto_q;
    assign houve_morte     = houve_q;
    assign erro_sel        = erro_q;
    assign pronto          = pronto_q;
    assign vitoria_lobo    = lobo_vivo && (vivos_cnt <= 3'd2);
    assign vitoria_aldeoes = !lobo_vivo;
    assign db_estado       = (estado_q <= FIM) ? 5'(estado_q) : 5'b11111;

endmodule

// File: tb/tb_resolve_noite.sv
// Scoreboard bench for resolve_noite: night results and selection errors are
// queued by the stimulus and checked by a monitor when the DUT pulses them.
module tb_resolve_noite;

    logic       clock = 1'b0;
    logic       reset;
    logic       novo_jogo, inicia, confirma;
    logic [9:0] jogo;
    logic [2:0] jogador_sel;
    logic [4:0] vivos;
    logic [2:0] morto_idx;
    logic       houve_morte, erro_sel, pronto, vitoria_lobo, vitoria_aldeoes;
    logic [4:0] db_estado;

    resolve_noite #(.N_JOG(5), .W_IDX(3)) dut (
        .clock(clock), .reset(reset), .novo_jogo(novo_jogo), .inicia(inicia),
        .jogo(jogo), .jogador_sel(jogador_sel), .confirma(confirma),
        .vivos(vivos), .morto_idx(morto_idx), .houve_morte(houve_morte),
        .erro_sel(erro_sel), .pronto(pronto), .vitoria_lobo(vitoria_lobo),
        .vitoria_aldeoes(vitoria_aldeoes), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0] vivos;
        logic [2:0] morto;
        logic       houve;
        int         cyc;
    } res_t;

    res_t pq[$];
    int   eq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every pronto / erro_sel pulse must match a queued expectation.
    always @(negedge clock) begin
        if (pronto === 1'b1) begin
            if (pq.size() == 0) begin
                chk("unexpected_pronto", 1, 0);
            end else begin
                res_t e;
                e = pq.pop_front();
                chk("pronto_cycle", cyc, e.cyc);
                chk("pronto_vivos", int'(vivos), int'(e.vivos));
                chk("pronto_houve", int'(houve_morte), int'(e.houve));
                chk("pronto_morto", int'(morto_idx), int'(e.morto));
            end
        end
        if (erro_sel === 1'b1) begin
            if (eq.size() == 0) begin
                chk("unexpected_erro", 1, 0);
            end else begin
                chk("erro_estado", int'(db_estado), eq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start();
        inicia = 1'b1;
        tick();
        inicia = 1'b0;
    endtask

    task automatic sel(input logic [2:0] s);
        jogador_sel = s;
        confirma    = 1'b1;
        tick();
        confirma    = 1'b0;
    endtask

    task automatic expect_err(input logic [2:0] s, input int st);
        eq.push_back(st);
        sel(s);
    endtask

    task automatic final_sel(input logic [2:0] s, input logic [4:0] v,
                             input logic [2:0] m, input logic h);
        res_t r;
        r.vivos = v; r.morto = m; r.houve = h; r.cyc = cyc + 3;
        pq.push_back(r);
        sel(s);
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 10 && (pq.size() != 0 || eq.size() != 0); i++) tick();
        chk({nm, "_drained"}, pq.size() + eq.size(), 0);
        tick();
        chk({nm, "_idle"}, int'(db_estado), 0);
    endtask

    initial begin
        res_t r;
        reset = 1'b0; novo_jogo = 1'b0; inicia = 1'b0; confirma = 1'b0;
        jogo = 10'b01_10_00_00_00; jogador_sel = 3'd0;
        tick();
        reset = 1'b1;
        chk("rst_vivos", int'(vivos), 5'b11111);
        chk("rst_estado", int'(db_estado), 0);
        chk("rst_pronto", int'(pronto), 0);
        chk("rst_houve", int'(houve_morte), 0);
        chk("rst_morto", int'(morto_idx), 0);

        // Wolf (p0) kills p3, doctor (p1) protects p1.
        start();
        chk("n1_estado_lobo", int'(db_estado), 1);
        sel(3'd3);
        chk("n1_estado_med", int'(db_estado), 2);
        final_sel(3'd1, 5'b10111, 3'd3, 1'b1);
        chk("n1_estado_res", int'(db_estado), 3);
        wait_done("n1");
        chk("n1_vit_lobo", int'(vitoria_lobo), 0);
        chk("n1_vit_ald", int'(vitoria_aldeoes), 0);

        // Doctor saves the wolf's target: mask and victim unchanged.
        start();
        sel(3'd2);
        final_sel(3'd2, 5'b10111, 3'd3, 1'b0);
        wait_done("n2");

        // Illegal wolf choices, novo_jogo ignored mid-night, then doctor kills p4.
        start();
        expect_err(3'd0, 1);
        expect_err(3'd6, 1);
        expect_err(3'd3, 1);
        chk("n3_estado_after_err", int'(db_estado), 1);
        novo_jogo = 1'b1;
        tick();
        novo_jogo = 1'b0;
        chk("n3_novo_ignored", int'(vivos), 5'b10111);
        sel(3'd4);
        chk("n3_estado_med", int'(db_estado), 2);
        expect_err(3'd3, 2);
        final_sel(3'd1, 5'b00111, 3'd4, 1'b1);
        wait_done("n3");
        chk("n3_vit_lobo", int'(vitoria_lobo), 0);

        // Kill p2: only wolf and doctor remain.
        start();
        sel(3'd2);
        final_sel(3'd1, 5'b00011, 3'd2, 1'b1);
        wait_done("n4");
        chk("n4_vit_lobo", int'(vitoria_lobo), 1);
        chk("n4_vit_ald", int'(vitoria_aldeoes), 0);

        // Wolf role moved onto dead p2: villagers win, inicia goes straight to FIM.
        jogo = 10'b00_10_01_00_00;
        #1;
        chk("ald_vit_ald", int'(vitoria_aldeoes), 1);
        chk("ald_vit_lobo", int'(vitoria_lobo), 0);
        r.vivos = 5'b00011; r.morto = 3'd2; r.houve = 1'b0; r.cyc = cyc + 2;
        pq.push_back(r);
        start();
        chk("ald_estado_fim", int'(db_estado), 4);
        wait_done("ald");

        // novo_jogo together with inicia: fresh mask and the night starts.
        jogo = 10'b01_10_00_00_00;
        novo_jogo = 1'b1;
        start();
        novo_jogo = 1'b0;
        chk("ng_vivos", int'(vivos), 5'b11111);
        chk("ng_estado", int'(db_estado), 1);
        sel(3'd3);
        final_sel(3'd4, 5'b10111, 3'd3, 1'b1);
        wait_done("ng");

        // Reset while the doctor is choosing: mask restored, no pronto.
        start();
        sel(3'd2);
        chk("rm_estado_med", int'(db_estado), 2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rm_estado", int'(db_estado), 0);
        chk("rm_vivos", int'(vivos), 5'b11111);
        chk("rm_houve", int'(houve_morte), 0);
        chk("rm_morto", int'(morto_idx), 0);
        for (int i = 0; i < 4; i++) tick();
        chk("rm_pronto", int'(pronto), 0);
        chk("end_queues", pq.size() + eq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
